// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU control and its iterative multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_PASS  = 2'b11;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // MUL treats both operands as signed; its low half is sign-agnostic anyway.
  function automatic logic md_a_signed(input logic [2:0] f3);
    return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_MULHSU) ||
           (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] f3);
    return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative multiply/divide datapath: one bit per step on operand magnitudes,
// sign fixup on the final step, and single-cycle handling of divide special cases.
module md_iter_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            last_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            special_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, mcand_q, result_q;
  logic [2:0]      f3_q;
  logic            neg_q, rneg_q;

  logic            a_neg, b_neg, is_div, div_zero, div_ovf, qbit;
  logic [XLEN-1:0] a_mag, b_mag, special_val, final_res, quot, rem;
  logic [XLEN:0]   sum, trial;
  logic [2*XLEN-1:0] prod, prod_fx;

  always_comb begin
    a_neg       = md_a_signed(funct3_i) && op_a_i[XLEN-1];
    b_neg       = md_b_signed(funct3_i) && op_b_i[XLEN-1];
    a_mag       = a_neg ? -op_a_i : op_a_i;
    b_mag       = b_neg ? -op_b_i : op_b_i;
    is_div      = funct3_i[2];
    div_zero    = is_div && (op_b_i == '0);
    div_ovf     = is_div && !funct3_i[0] && (op_a_i == MIN_VAL) && (op_b_i == '1);
    special_o   = div_zero || div_ovf;
    special_val = '0;
    if (div_zero)     special_val = funct3_i[1] ? op_a_i : '1;
    else if (div_ovf) special_val = funct3_i[1] ? '0 : MIN_VAL;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    trial = {acc_q, lo_q[XLEN-1]} - {1'b0, mcand_q};
    qbit  = !trial[XLEN];
    if (f3_q[2]) begin
      acc_d = qbit ? trial[XLEN-1:0] : {acc_q[XLEN-2:0], lo_q[XLEN-1]};
      lo_d  = {lo_q[XLEN-2:0], qbit};
    end else begin
      acc_d = sum[XLEN:1];
      lo_d  = {sum[0], lo_q[XLEN-1:1]};
    end
    prod    = {acc_d, lo_d};
    prod_fx = neg_q ? -prod : prod;
    quot    = neg_q ? -lo_d : lo_d;
    rem     = rneg_q ? -acc_d : acc_d;
    case (f3_q)
      MD_MUL:                       final_res = prod_fx[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_fx[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              final_res = quot;
      default:                      final_res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else if (start_i) begin
      acc_q   <= '0;
      lo_q    <= is_div ? a_mag : b_mag;
      mcand_q <= is_div ? b_mag : a_mag;
      f3_q    <= funct3_i;
      neg_q   <= a_neg ^ b_neg;
      rneg_q  <= a_neg;
      if (special_o) result_q <= special_val;
    end else if (step_i) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      if (last_i) result_q <= final_res;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/alu_md_control.sv
// EX-stage ALU control: decodes ALU_Sel and sequences the RV32M iterative unit,
// raising Stall while a multiply/divide is in flight.
module alu_md_control
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Valid_In,
  input  logic            Flush,
  input  logic [1:0]      ALU_Op,
  input  logic [2:0]      Funct_3,
  input  logic [6:0]      Funct_7,
  input  logic            Is_Imm,
  input  logic [XLEN-1:0] Op_A,
  input  logic [XLEN-1:0] Op_B,
  output logic [3:0]      ALU_Sel,
  output logic            Md_Sel,
  output logic [XLEN-1:0] Md_Result,
  output logic            Md_Done,
  output logic            Stall
);

  localparam int CNT_W = $clog2(XLEN);

  md_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic md_op, accept, start, step, last, special;

  assign md_op  = ENABLE_M && (ALU_Op == OP_RTYPE) && !Is_Imm && (Funct_7 == F7_MULDIV);
  assign accept = Valid_In && md_op && !Flush;
  assign Md_Sel = md_op;
  assign last   = (cnt_q == '0);

  // ADDI has no SUB form, so imm bit 30 only matters for register ops and shifts.
  always_comb begin
    ALU_Sel = ALU_PASS;
    case (ALU_Op)
      OP_ADD:  ALU_Sel = ALU_ADD;
      OP_SUB:  ALU_Sel = ALU_SUB;
      OP_PASS: ALU_Sel = ALU_PASS;
      default: begin
        if (!md_op) begin
          case (Funct_3)
            3'b000:  ALU_Sel = (!Is_Imm && Funct_7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  ALU_Sel = ALU_SLL;
            3'b010:  ALU_Sel = ALU_SLT;
            3'b011:  ALU_Sel = ALU_SLTU;
            3'b100:  ALU_Sel = ALU_XOR;
            3'b101:  ALU_Sel = Funct_7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  ALU_Sel = ALU_OR;
            3'b111:  ALU_Sel = ALU_AND;
            default: ALU_Sel = ALU_PASS;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    step    = 1'b0;
    Stall   = 1'b0;
    Md_Done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          start   = 1'b1;
          Stall   = 1'b1;
          cnt_d   = special ? '0 : CNT_W'(XLEN - 1);
          state_d = special ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (Flush) begin
          state_d = ST_IDLE;
        end else begin
          Stall = 1'b1;
          step  = 1'b1;
          if (last) state_d = ST_DONE;
          else      cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        // The pipeline advances on this edge, so go idle without re-accepting.
        Md_Done = !Flush;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .step_i    (step),
    .last_i    (last),
    .funct3_i  (Funct_3),
    .op_a_i    (Op_A),
    .op_b_i    (Op_B),
    .special_o (special),
    .result_o  (Md_Result)
  );

endmodule
